ssm_tile_sequencer: RTL and testbench
=====================================

Name: ssm_tile_sequencer

Overview:
- Tile-side responder of the start/done tile handshake used by the SSM tiling controller.
- Accepts a one-cycle start with one (H_TILE x P_TILE) tile of dt/dA/D/x operands and latches them.
- Feeds the elements one at a time, in order, to a pipelined FP16 element lane over a valid/ready interface.
- Gathers the lane results into y_tile and pulses done; y_tile is then held for the controller to collect.

Parameters:
H_TILE, 6, heads per tile
P_TILE, 4, head-dim elements per tile
DW, 16, FP16 word width
NE (localparam), H_TILE*P_TILE, elements per tile
IW (localparam), $clog2(NE), element index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle tile start pulse
dt_tile  in  H_TILE*DW  per-head dt, head h at [DW*h +: DW]
dA_tile  in  H_TILE*DW  per-head dA
D_tile  in  H_TILE*DW  per-head D
x_tile  in  NE*DW  element t at [DW*t +: DW]
op_valid  out  1  operand word valid to lane
op_ready  in  1  lane accepts operand
op_idx  out  IW  element index t
op_x  out  DW  x of element t
op_dt  out  DW  dt of head t/P_TILE
op_dA  out  DW  dA of head t/P_TILE
op_D  out  DW  D of head t/P_TILE
res_valid  in  1  lane result valid; results arrive in issue order; no backpressure
res_data  in  DW  lane result
y_tile  out  NE*DW  assembled tile output
done  out  1  one-cycle completion pulse
busy  out  1  high from start acceptance until done pulse, inclusive
err  out  1  sticky: unexpected result seen

Behaviour:
- Reset: state IDLE; counters 0; op_valid=0, op_idx=0, op_* operands=0, y_tile=0, done=0, busy=0, err=0. Reset mid-tile aborts immediately; no done is produced for the aborted tile.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches all tile inputs into internal regs; issue_cnt=0, res_cnt=0; go to RUN.
  - The next cycle has busy=1 and op_valid=1 with op_idx=0.
- RUN:
  - op_valid=1. Operands are taken from the latched copy at index issue_cnt: h_rel=issue_cnt/P_TILE, op_x=x[issue_cnt], op_dt/op_dA/op_D = head h_rel.
  - On op_valid&&op_ready: issue_cnt++.
  - When the transfer of element NE-1 completes: op_valid drops the next cycle; go to DRAIN (or straight to DONE if all results are already in).
  - While op_ready=0, op_idx and all operands are held stable.
- Result capture, in RUN and DRAIN:
  - On res_valid: y_tile[DW*res_cnt +: DW] <= res_data; res_cnt++.
  - Results may arrive in the same cycle as an issue; both are handled.
- Completion:
  - The capture edge that brings res_cnt to NE moves the state to DONE.
  - DONE lasts exactly one cycle: done=1, busy=1. The following cycle is IDLE: done=0, busy=0.
- y_tile hold:
  - y_tile is never cleared except by rst.
  - It holds the completed tile from the done pulse until the first result capture of the next tile.
- Unexpected results: res_valid while in IDLE or DONE (or with res_cnt==NE) is dropped, y_tile is unchanged, and err is set to 1. err clears only on rst.
- start handling:
  - start while busy is ignored.
  - start in the same cycle as DONE is ignored. The controller re-starts at least one cycle after done.
- Element ordering: element t ↔ (h_rel=t/P_TILE, p_rel=t%P_TILE). This matches the controller's x_tile and y_tile packing.
- Latency:
  - With op_ready=1 and lane latency L (result L cycles after the accepting edge), done is high in cycle NE+L+1 after the start edge.
  - Minimum start-to-start spacing is NE+L+2.

Test Plan:
1. Lane model with op_ready=1, L=3, res=x+1; x_tile[t]=t, start pulse → op_idx 0..23 on consecutive cycles; y_tile[t]=t+1 for all t; done high exactly one cycle (cycle 28 after start edge); busy=0 afterwards; err=0.
2. op_ready alternating 1/0, with a 5-cycle low burst at t=10 → op_idx sequence exactly 0..23, no skips or duplicates; op_dt for t=4..7 equals dt_tile head 1; operands stable while op_ready=0; y_tile correct; single done.
3. Second start at cycle 5 of an active tile → ignored: no counter reset and exactly one done; a start one cycle after done begins a new tile, and old y_tile stays visible until its first new result.
4. res_valid=1 with res_data=16'h3C00 while IDLE → err=1, y_tile unchanged, done stays 0; a subsequent full tile completes normally and err remains 1.
5. rst asserted asynchronously after 12 issued and 8 results → all outputs return to reset values at once, with no done; a fresh start then completes a full tile correctly.
6. Lane latency L=0 (result captured on the same edge as issue, overlapping issue and capture) → last result and last issue coincide, the block goes directly from RUN to DONE, and done appears one cycle later.

Source files
------------

// File: rtl/ssm_tile_sequencer.sv
// Tile-side responder for the SSM tiling controller's start/done handshake.
// It latches one H_TILE x P_TILE operand tile on start, issues the elements
// in order to a pipelined element lane over valid/ready, gathers the
// in-order results into y_tile and pulses done. y_tile then stays put for
// the controller to collect.
module ssm_tile_sequencer #(
   parameter  int H_TILE = 6,
   parameter  int P_TILE = 4,
   parameter  int DW     = 16,
   localparam int NE     = H_TILE * P_TILE,
   localparam int IW     = $clog2(NE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [H_TILE*DW-1:0] dt_tile,
   input  logic [H_TILE*DW-1:0] dA_tile,
   input  logic [H_TILE*DW-1:0] D_tile,
   input  logic [NE*DW-1:0]     x_tile,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [IW-1:0]        op_idx,
   output logic [DW-1:0]        op_x,
   output logic [DW-1:0]        op_dt,
   output logic [DW-1:0]        op_dA,
   output logic [DW-1:0]        op_D,
   input  logic                 res_valid,
   input  logic [DW-1:0]        res_data,
   output logic [NE*DW-1:0]     y_tile,
   output logic                 done,
   output logic                 busy,
   output logic                 err
);

   // The counters must be able to hold NE itself, one more than the last index.
   localparam int            CW   = $clog2(NE + 1);
   localparam logic [CW-1:0] LAST = CW'(NE - 1);
   localparam logic [CW-1:0] FULL = CW'(NE);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_issue_cnt;
   logic [CW-1:0]        r_res_cnt;
   logic [H_TILE*DW-1:0] r_dt;
   logic [H_TILE*DW-1:0] r_dA;
   logic [H_TILE*DW-1:0] r_D;
   logic [NE*DW-1:0]     r_x;
   logic [NE*DW-1:0]     r_y;
   logic                 r_err;

   logic                 w_start;
   logic                 w_issue;
   logic                 w_last_issue;
   logic                 w_cap;
   logic                 w_last_cap;
   logic                 w_unexp;
   logic [IW-1:0]        w_idx;
   logic [IW-1:0]        w_head;

   assign w_start      = (r_state == S_IDLE) && start;
   assign w_issue      = (r_state == S_RUN) && op_ready;
   assign w_last_issue = w_issue && (r_issue_cnt == LAST);
   // A result is only wanted while a tile is in flight and not yet full.
   assign w_cap        = res_valid && ((r_state == S_RUN) || (r_state == S_DRAIN))
                         && (r_res_cnt != FULL);
   assign w_last_cap   = w_cap && (r_res_cnt == LAST);
   assign w_unexp      = res_valid && !w_cap;
   // Element t belongs to head t / P_TILE (head-major packing).
   assign w_idx        = r_issue_cnt[IW-1:0];
   assign w_head       = w_idx / IW'(P_TILE);

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and output decode.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      op_valid    = 1'b0;
      op_idx      = '0;
      op_x        = '0;
      op_dt       = '0;
      op_dA       = '0;
      op_D        = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            op_valid = 1'b1;
            op_idx   = w_idx;
            op_x     = r_x[DW*w_idx +: DW];
            op_dt    = r_dt[DW*w_head +: DW];
            op_dA    = r_dA[DW*w_head +: DW];
            op_D     = r_D[DW*w_head +: DW];
            // With a zero-latency lane the last result lands with the last issue.
            if (w_last_issue) w_state_nxt = w_last_cap ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (w_last_cap) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand store: snapshot of the tile taken on an accepted start.
   // NOTE: this wide store is reset as well so the operand outputs and their
   // sources are defined from reset onward rather than left as X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dt <= '0;
         r_dA <= '0;
         r_D  <= '0;
         r_x  <= '0;
      end else if (w_start) begin
         r_dt <= dt_tile;
         r_dA <= dA_tile;
         r_D  <= D_tile;
         r_x  <= x_tile;
      end
   end

   // Issue and result counters; start clears them, transfers advance them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_cnt <= '0;
         r_res_cnt   <= '0;
      end else if (w_start) begin
         r_issue_cnt <= '0;
         r_res_cnt   <= '0;
      end else begin
         if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
         if (w_cap)   r_res_cnt   <= r_res_cnt + 1'b1;
      end
   end

   // Result gather into y_tile (kept until overwritten) and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y   <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_cap)   r_y[DW*r_res_cnt +: DW] <= res_data;
         if (w_unexp) r_err <= 1'b1;
      end
   end

   assign y_tile = r_y;
   assign err    = r_err;

endmodule

// File: tb/tb_ssm_tile_sequencer.sv
// Self-checking bench for ssm_tile_sequencer. A behavioural lane with
// configurable latency and op_ready pattern answers the issued operands;
// expected operands and y_tile come from the tile arrays held here.
module tb_ssm_tile_sequencer;

   localparam int H  = 6;
   localparam int P  = 4;
   localparam int DW = 16;
   localparam int NE = H * P;
   localparam int IW = $clog2(NE);
   localparam int YW = NE * DW;
   localparam int OW = 1 + IW + 4 * DW;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [H*DW-1:0] dt_tile, dA_tile, D_tile;
   logic [NE*DW-1:0] x_tile;
   logic           op_valid;
   logic           op_ready;
   logic [IW-1:0]  op_idx;
   logic [DW-1:0]  op_x, op_dt, op_dA, op_D;
   logic           res_valid;
   logic [DW-1:0]  res_data;
   logic [YW-1:0]  y_tile;
   logic           done, busy, err;

   ssm_tile_sequencer #(.H_TILE(H), .P_TILE(P), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .dt_tile(dt_tile), .dA_tile(dA_tile), .D_tile(D_tile), .x_tile(x_tile),
      .op_valid(op_valid), .op_ready(op_ready), .op_idx(op_idx),
      .op_x(op_x), .op_dt(op_dt), .op_dA(op_dA), .op_D(op_D),
      .res_valid(res_valid), .res_data(res_data),
      .y_tile(y_tile), .done(done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Tile contents as the controller sees them.
   logic [DW-1:0] m_x [NE];
   logic [DW-1:0] m_dt[H];
   logic [DW-1:0] m_dA[H];
   logic [DW-1:0] m_D [H];
   logic [YW-1:0] y_hold;
   logic          exp_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   int cyc      = 0;

   // Lane configuration, set by the test sequence.
   int            lat      = 3;
   int            rdy_mode = 0;
   logic          inj      = 1'b0;
   logic [DW-1:0] inj_data = '0;

   task automatic check(input string tag, input logic [YW-1:0] act, input logic [YW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [YW-1:0] exp_y();
      logic [YW-1:0] y;
      for (int t = 0; t < NE; t++)
         y[DW*t +: DW] = m_x[t] + m_dt[t/P] + m_dA[t/P] + m_D[t/P] + 16'd1;
      return y;
   endfunction

   task automatic set_tile(input bit zero_heads, input bit ramp_x);
      for (int h = 0; h < H; h++) begin
         m_dt[h] = zero_heads ? '0 : DW'($urandom);
         m_dA[h] = zero_heads ? '0 : DW'($urandom);
         m_D[h]  = zero_heads ? '0 : DW'($urandom);
         dt_tile[DW*h +: DW] = m_dt[h];
         dA_tile[DW*h +: DW] = m_dA[h];
         D_tile[DW*h +: DW]  = m_D[h];
      end
      for (int t = 0; t < NE; t++) begin
         m_x[t] = ramp_x ? DW'(t) : DW'($urandom);
         x_tile[DW*t +: DW] = m_x[t];
      end
   endtask

   always @(posedge clk) cyc++;
   always @(negedge clk) if (done) n_done++;

   // Behavioural lane: chooses op_ready, checks each accepted operand against
   // the tile arrays, and returns x+dt+dA+D+1 exactly lat edges after acceptance.
   typedef struct { int due; logic [DW-1:0] data; } res_t;
   res_t          q[$];
   int            exp_next   = 0;
   bit            burst_done = 0;
   int            burst_left = 0;
   bit            alt        = 0;
   bit            was_stall  = 0;
   logic [OW-1:0] held;
   logic          lv;
   logic [DW-1:0] ld;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         op_ready  = 1'b0;
         res_valid = 1'b0;
         res_data  = '0;
         was_stall = 0;
      end else begin
         if (start && !busy) begin
            exp_next   = 0;
            burst_done = 0;
            burst_left = 0;
            alt        = 0;
            q.delete();
         end
         if (was_stall)
            check("stall_hold", {op_valid, op_idx, op_x, op_dt, op_dA, op_D}, held);
         case (rdy_mode)
            0: op_ready = 1'b1;
            1: begin
               if (burst_left > 0) begin
                  burst_left--;
                  op_ready = 1'b0;
               end else if (op_valid && op_idx == IW'(10) && !burst_done) begin
                  burst_done = 1;
                  burst_left = 4;
                  op_ready   = 1'b0;
               end else begin
                  alt      = !alt;
                  op_ready = alt;
               end
            end
            default: op_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (op_valid && op_ready) begin
            check("idx_in_range", exp_next < NE, 1);
            if (exp_next < NE) begin
               check("op_idx", op_idx, exp_next);
               check("op_x",   op_x,   m_x[exp_next]);
               check("op_dt",  op_dt,  m_dt[exp_next/P]);
               check("op_dA",  op_dA,  m_dA[exp_next/P]);
               check("op_D",   op_D,   m_D[exp_next/P]);
            end
            q.push_back('{due: cyc + 1 + lat, data: op_x + op_dt + op_dA + op_D + 16'd1});
            exp_next++;
         end
         was_stall = op_valid && !op_ready;
         held      = {op_valid, op_idx, op_x, op_dt, op_dA, op_D};
         lv = 1'b0;
         ld = '0;
         if (q.size() > 0 && q[0].due == cyc + 1) begin
            lv = 1'b1;
            ld = q[0].data;
            void'(q.pop_front());
         end
         res_valid = inj || lv;
         res_data  = inj ? inj_data : ld;
      end
   end

   // One full tile: start, optional extra start at cycle xs, wait for done.
   task automatic run_tile(input int l, input int mode, input int xs,
                           input bit zero_heads, input bit ramp_x);
      int k;
      int d0;
      bit got;
      lat      = l;
      rdy_mode = mode;
      set_tile(zero_heads, ramp_x);
      d0    = n_done;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start",  busy,     1);
      check("valid_after_start", op_valid, 1);
      check("idx_after_start",   op_idx,   0);
      check("y_held_old_tile",   y_tile,   y_hold);
      k   = 0;
      got = 0;
      while (!got && k < 400) begin
         start = (k == xs);
         tick();
         k++;
         if (done) got = 1;
      end
      start = 1'b0;
      check("done_seen", got, 1);
      // Cycle 1 is the cycle right after the start edge.
      if (mode == 0) check("done_cycle", k + 1, NE + l + 1);
      check("busy_in_done", busy,   1);
      check("y_tile",       y_tile, exp_y());
      tick();
      check("done_one_cycle", done,         0);
      check("busy_after",     busy,         0);
      check("valid_idle",     op_valid,     0);
      check("done_count",     n_done - d0,  1);
      check("err_flag",       err,          exp_err);
      y_hold = exp_y();
   endtask

   initial begin
      int d0;
      rst     = 1'b1;
      start   = 1'b0;
      dt_tile = '0;
      dA_tile = '0;
      D_tile  = '0;
      x_tile  = '0;
      y_hold  = '0;
      exp_err = 1'b0;
      repeat (2) tick();
      check("rst_busy",  busy,     0);
      check("rst_valid", op_valid, 0);
      check("rst_done",  done,     0);
      check("rst_err",   err,      0);
      check("rst_idx",   op_idx,   0);
      check("rst_x",     op_x,     0);
      check("rst_y",     y_tile,   0);
      rst = 1'b0;
      tick();

      // Ramp x, zero heads, L=3, always ready: y[t] = t+1, done at cycle 28.
      run_tile(3, 0, -1, 1, 1);
      // Alternating ready with a 5-cycle stall at element 10.
      run_tile(2, 1, -1, 0, 0);
      // Stray start mid-tile, then a start right after done.
      run_tile(3, 0, 5, 0, 0);
      run_tile(3, 0, -1, 0, 0);

      // Result while idle: dropped and flagged.
      inj_data = 16'h3C00;
      inj      = 1'b1;
      tick();
      inj = 1'b0;
      check("unexp_err",  err,    1);
      check("unexp_y",    y_tile, y_hold);
      check("unexp_done", done,   0);
      exp_err = 1'b1;
      tick();
      run_tile(3, 0, -1, 0, 0);

      // Zero-latency lane: last issue and last capture coincide.
      run_tile(0, 0, -1, 0, 0);

      // Asynchronous reset after 12 issues and 8 results (L=4).
      lat      = 4;
      rdy_mode = 0;
      set_tile(0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      d0    = n_done;
      repeat (12) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy",  busy,     0);
      check("arst_valid", op_valid, 0);
      check("arst_idx",   op_idx,   0);
      check("arst_ops",   {op_x, op_dt, op_dA, op_D}, 0);
      check("arst_y",     y_tile,   0);
      check("arst_done",  done,     0);
      check("arst_err",   err,      0);
      y_hold  = '0;
      exp_err = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("arst_no_done", n_done - d0, 0);
      run_tile(3, 0, -1, 0, 0);

      // Randomised tiles: random latency and ready pattern.
      for (int i = 0; i < 6; i++)
         run_tile($urandom_range(0, 5), $urandom_range(0, 2), -1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
